// File: rtl/sprite_compositor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_compositor_pkg
// Description : Shared definitions for the sprite compositor: coordinate and
//               colour widths, fixed colours, player orientation encodings,
//               the per-pixel flag bundle carried down the pipeline and the
//               final colour priority function.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_compositor_pkg;

    localparam int COL_W = 10;
    localparam int ROW_W = 9;
    localparam int RGB_W = 12;

    localparam logic [RGB_W-1:0] WALL_RGB = 12'hFFF;
    localparam logic [RGB_W-1:0] BEAN_RGB = 12'hFF0;
    localparam logic [RGB_W-1:0] BLACK    = 12'h000;

    // Player orientation. Ghosts always use DIR_NORMAL.
    typedef enum logic [1:0] {
        DIR_TRANSPOSE      = 2'b00,
        DIR_TRANSPOSE_FLIP = 2'b01,
        DIR_NORMAL         = 2'b10,
        DIR_MIRROR         = 2'b11
    } pac_dir_e;

    // Per-pixel attributes that travel alongside the ROM access.
    typedef struct packed {
        logic valid;
        logic over;
        logic wall;
        logic bean;
        logic ghost;   // a ghost won stage-1 arbitration
        logic player;  // the player was selected (no ghost covered the pixel)
    } pix_flags_t;

    // Final colour priority: blanking, wall, opaque ghost, bean, opaque player.
    function automatic logic [RGB_W-1:0] compose_rgb(
        input pix_flags_t       f,
        input logic [RGB_W-1:0] texel_rgb,
        input logic [RGB_W-1:0] key_rgb
    );
        logic [RGB_W-1:0] rgb;
        if (f.over)
            rgb = BLACK;
        else if (f.wall)
            rgb = WALL_RGB;
        else if (f.ghost && (texel_rgb != key_rgb))
            rgb = texel_rgb;
        else if (f.bean)
            rgb = BEAN_RGB;
        else if (f.player && (texel_rgb != key_rgb))
            rgb = texel_rgb;
        else
            rgb = BLACK;
        return rgb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_compositor_hit.sv
`default_nettype none
// ============================================================================
// Module      : sprite_hit
// Description : Combinational bounds test of one sprite against the current
//               pixel, plus the oriented texel address {row, col} inside the
//               sprite bitmap.
// Ports       : spr_x/spr_y   sprite top-left corner
//               spr_en        sprite visible
//               dir           texel orientation
//               col_addr/row_addr  current pixel
//               hit           pixel lies inside a visible sprite
//               texel         {texel row, texel col}
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_hit
    import sprite_compositor_pkg::*;
#(
    parameter int SPR_LOG = 5
) (
    input  logic [COL_W-1:0]     spr_x,
    input  logic [ROW_W-1:0]     spr_y,
    input  logic                 spr_en,
    input  pac_dir_e             dir,
    input  logic [COL_W-1:0]     col_addr,
    input  logic [ROW_W-1:0]     row_addr,
    output logic                 hit,
    output logic [2*SPR_LOG-1:0] texel
);

    localparam logic [COL_W:0]     C_COL_SPAN = (COL_W+1)'(2**SPR_LOG);
    localparam logic [ROW_W:0]     C_ROW_SPAN = (ROW_W+1)'(2**SPR_LOG);
    localparam logic [SPR_LOG-1:0] C_TEX_MAX  = {SPR_LOG{1'b1}};

    logic               w_in_col;
    logic               w_in_row;
    logic [SPR_LOG-1:0] w_dx;
    logic [SPR_LOG-1:0] w_dy;

    // One extra bit so a sprite near the right/bottom edge does not wrap
    // around and wrongly match pixels at the start of the line/frame.
    assign w_in_col = ({1'b0, col_addr} >= {1'b0, spr_x}) &&
                      ({1'b0, col_addr} <  ({1'b0, spr_x} + C_COL_SPAN));
    assign w_in_row = ({1'b0, row_addr} >= {1'b0, spr_y}) &&
                      ({1'b0, row_addr} <  ({1'b0, spr_y} + C_ROW_SPAN));

    assign hit = spr_en && w_in_col && w_in_row;

    // Offsets are only meaningful inside the sprite, so modulo-2^SPR_LOG
    // subtraction of the low bits is exact there.
    assign w_dx = col_addr[SPR_LOG-1:0] - spr_x[SPR_LOG-1:0];
    assign w_dy = row_addr[SPR_LOG-1:0] - spr_y[SPR_LOG-1:0];

    always_comb begin
        texel = {w_dy, w_dx};
        case (dir)
            DIR_TRANSPOSE:      texel = {w_dx, w_dy};
            DIR_TRANSPOSE_FLIP: texel = {w_dx, C_TEX_MAX - w_dy};
            DIR_NORMAL:         texel = {w_dy, w_dx};
            DIR_MIRROR:         texel = {w_dy, C_TEX_MAX - w_dx};
            default:            texel = {w_dy, w_dx};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module      : sprite_compositor
// Description : Three-stage pixel pipeline overlaying NUM_SPR sprites (index 0
//               player, others ghosts) on a wall/bean background.
//               Stage 1: hit test + arbitration, issues sprite ROM address.
//               Stage 2: registered sprite ROM read (external).
//               Stage 3: colour priority, registered output.
// Ports       : clk, rst                  clock, synchronous active-high reset
//               pix_en, frame_start       pixel strobe, first-pixel pulse
//               col_addr, row_addr        current pixel
//               is_wall, is_bean, over    background / blanking
//               spr_x, spr_y, spr_en      packed sprite state (frame-latched)
//               pac_dir                   player orientation (frame-latched)
//               rom_id, rom_addr, rom_rgb sprite ROM interface
//               rgb_out, rgb_valid        composited colour
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int                NUM_SPR  = 5,
    parameter int                SPR_LOG  = 5,
    parameter int                ANIM_DIV = 8,
    parameter logic [RGB_W-1:0]  KEY_RGB  = 12'h000,
    localparam int               ID_W     = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    localparam int               ADDR_W   = 2*SPR_LOG + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_en,
    input  logic                     frame_start,
    input  logic [COL_W-1:0]         col_addr,
    input  logic [ROW_W-1:0]         row_addr,
    input  logic                     is_wall,
    input  logic                     is_bean,
    input  logic                     over,
    input  logic [COL_W*NUM_SPR-1:0] spr_x,
    input  logic [ROW_W*NUM_SPR-1:0] spr_y,
    input  logic [NUM_SPR-1:0]       spr_en,
    input  logic [1:0]               pac_dir,
    output logic [ID_W-1:0]          rom_id,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [RGB_W-1:0]         rom_rgb,
    output logic [RGB_W-1:0]         rgb_out,
    output logic                     rgb_valid
);

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(ANIM_DIV - 1);

    // ------------------------------------------------------------------
    // Frame-latched sprite state
    // ------------------------------------------------------------------
    logic [COL_W*NUM_SPR-1:0] r_spr_x;
    logic [ROW_W*NUM_SPR-1:0] r_spr_y;
    logic [NUM_SPR-1:0]       r_spr_en;
    pac_dir_e                 r_pac_dir;
    logic [CNT_W-1:0]         r_frame_cnt;
    logic                     r_anim_phase;

    // Stage 1 compares against the values latched before this edge, so a
    // frame_start pixel still uses the previous frame's sprite state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spr_x      <= '0;
            r_spr_y      <= '0;
            r_spr_en     <= '0;
            r_pac_dir    <= DIR_TRANSPOSE;
            r_frame_cnt  <= '0;
            r_anim_phase <= 1'b0;
        end else if (pix_en && frame_start) begin
            r_spr_x   <= spr_x;
            r_spr_y   <= spr_y;
            r_spr_en  <= spr_en;
            r_pac_dir <= pac_dir_e'(pac_dir);
            if (r_frame_cnt == C_CNT_LAST) begin
                r_frame_cnt  <= '0;
                r_anim_phase <= ~r_anim_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-sprite hit test
    // ------------------------------------------------------------------
    logic [NUM_SPR-1:0]   w_hit;
    logic [2*SPR_LOG-1:0] w_texel [NUM_SPR];

    for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_spr
        sprite_hit #(
            .SPR_LOG (SPR_LOG)
        ) u_hit (
            .spr_x    (r_spr_x[COL_W*gi +: COL_W]),
            .spr_y    (r_spr_y[ROW_W*gi +: ROW_W]),
            .spr_en   (r_spr_en[gi]),
            .dir      ((gi == 0) ? r_pac_dir : DIR_NORMAL),
            .col_addr (col_addr),
            .row_addr (row_addr),
            .hit      (w_hit[gi]),
            .texel    (w_texel[gi])
        );
    end

    // ------------------------------------------------------------------
    // Arbitration: lowest-index ghost wins; player only if no ghost hits.
    // ------------------------------------------------------------------
    logic [ID_W-1:0]      w_win_id;
    logic [2*SPR_LOG-1:0] w_win_texel;
    logic                 w_ghost_hit;
    logic                 w_player_sel;
    logic                 w_any_hit;
    pix_flags_t           w_s1_flags;

    always_comb begin
        w_win_id    = '0;
        w_win_texel = w_texel[0];
        w_ghost_hit = 1'b0;
        // Scan downwards so the lowest-index ghost is the last to overwrite.
        for (int i = NUM_SPR - 1; i >= 1; i--) begin
            if (w_hit[i]) begin
                w_win_id    = ID_W'(i);
                w_win_texel = w_texel[i];
                w_ghost_hit = 1'b1;
            end
        end
    end

    // The player flag only follows a player selection: when a ghost wins,
    // the single ROM fetch returns ghost data, never player data.
    assign w_player_sel = w_hit[0] && !w_ghost_hit;
    assign w_any_hit    = w_ghost_hit || w_hit[0];

    always_comb begin
        w_s1_flags        = '0;
        w_s1_flags.valid  = 1'b1;
        w_s1_flags.over   = over;
        w_s1_flags.wall   = is_wall;
        w_s1_flags.bean   = is_bean;
        w_s1_flags.ghost  = w_ghost_hit;
        w_s1_flags.player = w_player_sel;
    end

    // ------------------------------------------------------------------
    // Pipeline: stage 1 (ROM address), stage 2 (ROM read), stage 3 (colour)
    // ------------------------------------------------------------------
    pix_flags_t r1_flags;
    pix_flags_t r2_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_id    <= '0;
            rom_addr  <= '0;
            r1_flags  <= '0;
            r2_flags  <= '0;
            rgb_out   <= BLACK;
            rgb_valid <= 1'b0;
        end else if (pix_en) begin
            // With no hit the address is left alone so the ROM is not
            // toggled needlessly; its data is ignored downstream.
            if (w_any_hit) begin
                rom_id   <= w_win_id;
                rom_addr <= {r_anim_phase, w_win_texel};
            end
            r1_flags  <= w_s1_flags;
            // The external ROM registers rom_addr on this same edge.
            r2_flags  <= r1_flags;
            rgb_out   <= compose_rgb(r2_flags, rom_rgb, KEY_RGB);
            rgb_valid <= r2_flags.valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_compositor
// Description : Self-checking bench for sprite_compositor. Pixel records hold
//               inputs and expected ROM request / colour; a queue carries
//               them to a monitor that aligns them with the 1- and 3-stage
//               pipeline outputs. Includes a registered sprite ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_compositor;

    localparam int NUM_SPR  = 5;
    localparam int SPR_LOG  = 5;
    localparam int ANIM_DIV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        frame_start;
    logic [9:0]  col_addr;
    logic [8:0]  row_addr;
    logic        is_wall;
    logic        is_bean;
    logic        over;
    logic [49:0] spr_x;
    logic [44:0] spr_y;
    logic [4:0]  spr_en;
    logic [1:0]  pac_dir;
    logic [2:0]  rom_id;
    logic [10:0] rom_addr;
    logic [11:0] rom_rgb;
    logic [11:0] rgb_out;
    logic        rgb_valid;

    always #5 clk = ~clk;

    sprite_compositor #(
        .NUM_SPR  (NUM_SPR),
        .SPR_LOG  (SPR_LOG),
        .ANIM_DIV (ANIM_DIV),
        .KEY_RGB  (12'h000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .frame_start (frame_start),
        .col_addr    (col_addr),
        .row_addr    (row_addr),
        .is_wall     (is_wall),
        .is_bean     (is_bean),
        .over        (over),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_en      (spr_en),
        .pac_dir     (pac_dir),
        .rom_id      (rom_id),
        .rom_addr    (rom_addr),
        .rom_rgb     (rom_rgb),
        .rgb_out     (rgb_out),
        .rgb_valid   (rgb_valid)
    );

    // Sprite ROM: one flat colour per sprite, texel column 31 transparent.
    function automatic logic [11:0] rom_fn(input logic [2:0] id, input logic [10:0] addr);
        if (addr[4:0] == 5'd31) return 12'h000;
        case (id)
            3'd0:    return 12'hFA0;
            3'd1:    return 12'h0F0;
            3'd2:    return 12'hF00;
            3'd3:    return 12'h0FF;
            default: return 12'hF0F;
        endcase
    endfunction

    initial rom_rgb = 12'h000;
    always @(posedge clk) if (pix_en) rom_rgb <= rom_fn(rom_id, rom_addr);

    typedef struct {
        logic [9:0]  col;
        logic [8:0]  row;
        logic        wall;
        logic        bean;
        logic        over;
        logic        fs;
        logic [11:0] rgb;
        logic        chk_rom;
        logic [2:0]  id;
        logic [10:0] addr;
    } vec_t;

    function automatic vec_t mk(input int col, input int row, input bit wall, input bit bean,
                                input bit ov, input bit fs, input logic [11:0] rgb,
                                input bit chk_rom, input int id, input logic [10:0] addr);
        vec_t v;
        v.col = 10'(col); v.row = 9'(row); v.wall = wall; v.bean = bean; v.over = ov;
        v.fs = fs; v.rgb = rgb; v.chk_rom = chk_rom; v.id = 3'(id); v.addr = addr;
        return v;
    endfunction

    vec_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    vec_t        s1, s2, s3;
    bit          v1 = 0, v2 = 0, v3 = 0;
    logic [11:0] last_rgb;
    logic        last_valid;
    logic [10:0] last_addr;
    logic [2:0]  last_id;
    bit          was_en, was_rst;

    always @(posedge clk) begin
        was_en  = pix_en;
        was_rst = rst;
        #1;
        if (was_rst) begin
            check("reset rgb_out", rgb_out, 12'h000);
            check("reset rgb_valid", 12'(rgb_valid), 12'h0);
            check("reset rom_id", 12'(rom_id), 12'h0);
            check("reset rom_addr", 12'(rom_addr), 12'h0);
            v1 = 0; v2 = 0; v3 = 0;
            q.delete();
        end else if (was_en) begin
            v3 = v2; s3 = s2;
            v2 = v1; s2 = s1;
            if (q.size() > 0) begin
                s1 = q.pop_front();
                v1 = 1;
            end else begin
                v1 = 0;
            end
            if (v1 && s1.chk_rom) begin
                check("rom_id", 12'(rom_id), 12'(s1.id));
                check("rom_addr", 12'(rom_addr), 12'(s1.addr));
            end
            check("rgb_valid", 12'(rgb_valid), 12'(v3));
            if (v3) check("rgb_out", rgb_out, s3.rgb);
        end else begin
            check("hold rgb_out", rgb_out, last_rgb);
            check("hold rgb_valid", 12'(rgb_valid), 12'(last_valid));
            check("hold rom_addr", 12'(rom_addr), 12'(last_addr));
            check("hold rom_id", 12'(rom_id), 12'(last_id));
        end
        last_rgb   = rgb_out;
        last_valid = rgb_valid;
        last_addr  = rom_addr;
        last_id    = rom_id;
    end

    // ---------------- driver ----------------
    task automatic drive(input vec_t v);
        @(negedge clk);
        pix_en      = 1'b1;
        frame_start = v.fs;
        col_addr    = v.col;
        row_addr    = v.row;
        is_wall     = v.wall;
        is_bean     = v.bean;
        over        = v.over;
        q.push_back(v);
    endtask

    // Disabled cycles with junk on every pixel input, including frame_start.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_en      = 1'b0;
            frame_start = 1'b1;
            col_addr    = 10'($urandom);
            row_addr    = 9'($urandom);
            is_wall     = 1'b1;
            is_bean     = 1'b1;
            over        = 1'b1;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[15];

    initial begin
        // col row wall bean over fs rgb chk id addr
        tbl[0]  = mk(0,    0,   0, 0, 0, 1, 12'h000, 1, 0, 11'h000); // shadows still empty
        tbl[1]  = mk(110,  60,  0, 0, 0, 0, 12'h0F0, 1, 1, 11'h14A); // ghost 1 texel (10,10)
        tbl[2]  = mk(3,    5,   0, 0, 0, 0, 12'hFA0, 1, 0, 11'h07A); // player dir 01 -> {3,26}
        tbl[3]  = mk(3,    5,   0, 1, 0, 0, 12'hFF0, 1, 0, 11'h07A); // bean beats player
        tbl[4]  = mk(131,  60,  0, 1, 0, 0, 12'hFF0, 1, 1, 11'h15F); // ghosts 1,2; key -> bean
        tbl[5]  = mk(120,  80,  1, 0, 0, 0, 12'hFFF, 1, 1, 11'h3D4); // wall beats ghost
        tbl[6]  = mk(120,  80,  1, 0, 1, 0, 12'h000, 1, 1, 11'h3D4); // over blanks all
        tbl[7]  = mk(132,  60,  0, 0, 0, 0, 12'hF00, 1, 2, 11'h0B6); // just past ghost 1
        tbl[8]  = mk(500,  300, 0, 0, 0, 0, 12'h000, 1, 2, 11'h0B6); // no hit: ROM req held
        tbl[9]  = mk(500,  300, 0, 1, 0, 0, 12'hFF0, 1, 2, 11'h0B6);
        tbl[10] = mk(610,  410, 0, 0, 0, 0, 12'h000, 1, 2, 11'h0B6); // hidden sprite 4
        tbl[11] = mk(31,   31,  0, 0, 0, 0, 12'hFA0, 1, 0, 11'h3E0); // player far corner
        tbl[12] = mk(32,   5,   0, 0, 0, 0, 12'h000, 1, 0, 11'h3E0); // one past player
        tbl[13] = mk(1010, 500, 0, 0, 0, 0, 12'h0FF, 1, 3, 11'h14A); // edge sprite, no wrap
        tbl[14] = mk(1023, 511, 0, 0, 0, 0, 12'h0FF, 1, 3, 11'h2B7);

        rst = 1'b1; pix_en = 1'b0; frame_start = 1'b0;
        col_addr = '0; row_addr = '0; is_wall = 0; is_bean = 0; over = 0;
        spr_x   = {10'd600, 10'd1000, 10'd110, 10'd100, 10'd0};
        spr_y   = {9'd400,  9'd490,   9'd55,   9'd50,   9'd0};
        spr_en  = 5'b01111;
        pac_dir = 2'b01;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < 15; i++) drive(tbl[i]);

        // Mid-frame changes must wait for the next frame_start.
        drive(mk(110, 60, 0, 0, 0, 0, 12'h0F0, 1, 1, 11'h14A));
        spr_x[19:10] = 10'd400;
        pac_dir      = 2'b11;
        drive(mk(110, 60,  0, 0, 0, 0, 12'h0F0, 1, 1, 11'h14A));
        drive(mk(3,   5,   0, 0, 0, 0, 12'hFA0, 1, 0, 11'h07A));
        drive(mk(500, 300, 0, 0, 0, 1, 12'h000, 1, 0, 11'h07A)); // frame 2: phase -> 1
        drive(mk(110, 60,  0, 0, 0, 0, 12'hF00, 1, 2, 11'h4A0));
        drive(mk(410, 60,  0, 0, 0, 0, 12'h0F0, 1, 1, 11'h54A));
        drive(mk(3,   5,   0, 0, 0, 0, 12'hFA0, 1, 0, 11'h4BC)); // dir 11 -> {5,28}
        idle(5);
        drive(mk(410, 60,  1, 0, 1, 0, 12'h000, 1, 1, 11'h54A));
        drive(mk(500, 300, 0, 0, 0, 1, 12'h000, 1, 1, 11'h54A)); // frame 3: phase stays 1
        drive(mk(3,   5,   0, 0, 0, 0, 12'hFA0, 1, 0, 11'h4BC));
        drive(mk(500, 300, 0, 0, 0, 1, 12'h000, 1, 0, 11'h4BC)); // frame 4: phase -> 0
        drive(mk(3,   5,   0, 0, 0, 0, 12'hFA0, 1, 0, 11'h0BC));
        drive(mk(500, 300, 0, 0, 0, 0, 12'h000, 0, 0, 11'h000));
        drive(mk(500, 300, 0, 0, 0, 0, 12'h000, 0, 0, 11'h000));

        // Reset mid-frame, with pix_en and frame_start also high.
        @(negedge clk);
        rst = 1'b1; pix_en = 1'b1; frame_start = 1'b1;
        col_addr = 10'd410; row_addr = 9'd60; is_wall = 0; is_bean = 0; over = 0;
        @(negedge clk);
        rst = 1'b0; pix_en = 1'b0; frame_start = 1'b0;
        drive(mk(410, 60,  0, 0, 0, 0, 12'h000, 1, 0, 11'h000)); // all sprites hidden
        drive(mk(0,   0,   0, 0, 0, 1, 12'h000, 1, 0, 11'h000));
        drive(mk(410, 60,  0, 0, 0, 0, 12'h0F0, 1, 1, 11'h14A));
        drive(mk(3,   5,   0, 0, 0, 0, 12'hFA0, 1, 0, 11'h0BC));
        drive(mk(500, 300, 0, 1, 0, 0, 12'hFF0, 1, 0, 11'h0BC));
        drive(mk(500, 300, 0, 0, 0, 0, 12'h000, 0, 0, 11'h000));
        drive(mk(500, 300, 0, 0, 0, 0, 12'h000, 0, 0, 11'h000));
        @(negedge clk);
        pix_en = 1'b0; frame_start = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter NUM_SPR, default 5: number of sprites; sprite 0 is the player, 1..NUM_SPR-1 are ghosts.
REQ-002 Parameter SPR_LOG, default 5: sprite edge = 2^SPR_LOG pixels (32).
REQ-003 Parameter ANIM_DIV, default 8: frames per animation phase toggle.
REQ-004 Parameter KEY_RGB, default 12'h000: transparent colour in sprite ROM data.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pix_en  in  1  pixel strobe; pipeline advances only on clk edges where pix_en=1.
REQ-008 frame_start  in  1  one-clk pulse at the first pixel of each frame; qualified by pix_en.
REQ-009 col_addr  in  10  current pixel column.
REQ-010 row_addr  in  9  current pixel row.
REQ-011 is_wall / is_bean  in  1 each  background map hits for the current pixel.
REQ-012 over  in  1  game-over blanking.
REQ-013 spr_x  in  10*NUM_SPR  packed sprite X, sprite i at bits [10i+9:10i].
REQ-014 spr_y  in  9*NUM_SPR  packed sprite Y.
REQ-015 spr_en  in  NUM_SPR  per-sprite visibility.
REQ-016 pac_dir  in  2  player orientation: 00 transpose, 01 transpose+flip-row, 10 normal, 11 mirror-col.
REQ-017 rom_id  out  $clog2(NUM_SPR)  selected sprite to the sprite ROM.
REQ-018 rom_addr  out  2*SPR_LOG+1  {anim_phase, texel row, texel col} to the sprite ROM.
REQ-019 rom_rgb  in  12  sprite ROM data, registered ROM, valid one pixel-stage after rom_addr.
REQ-020 rgb_out  out  12  composited colour; rgb_valid  out  1  rgb_out corresponds to a pixel.

Function
REQ-021 Positions, spr_en and pac_dir SHALL be captured into shadow registers on frame_start and used for the whole frame (no mid-frame tearing).
REQ-022 Frame counter SHALL count frame_start pulses modulo ANIM_DIV; anim_phase SHALL toggle on wrap to 0.
REQ-023 Stage 1: hit for sprite i iff spr_en[i] and x_i <= col < x_i+2^SPR_LOG and y_i <= row < y_i+2^SPR_LOG; comparisons at 11/10-bit width (no wrap past 1023/511).
REQ-024 Stage 1: lowest-index hitting sprite SHALL win among ghosts; player loses to any ghost; rom_id, rom_addr registered.
REQ-025 Player texel offsets: dx=col-x0, dy=row-y0; dir 00 addr {dx,dy}; 01 {dx,2^SPR_LOG-1-dy}; 10 {dy,dx}; 11 {dy,2^SPR_LOG-1-dx}.
REQ-026 Stage 2: ROM read; wall, bean, over, hit flag delayed alongside.
REQ-027 Stage 3 priority, registered: over -> 12'h000; wall -> 12'hFFF; ghost hit with rom_rgb != KEY_RGB -> rom_rgb; bean -> 12'hFF0; player hit non-key -> rom_rgb; else 12'h000.
REQ-028 Latency SHALL be exactly 3 pix_en-qualified clk edges from pixel input to rgb_out; rgb_valid asserts after 3 enabled edges since reset.
REQ-029 Clk edges with pix_en=0 SHALL hold all pipeline registers unchanged.
REQ-030 frame_start coinciding with a stage-1 compare: new shadow values apply from the next pixel.
REQ-031 No hit -> rom_id and rom_addr hold previous values.

Reset
REQ-032 rst SHALL clear shadow registers, spr_en shadow (all sprites hidden), frame counter, anim_phase, pipeline flags, rgb_out=12'h000, rgb_valid=0, rom_id=0, rom_addr=0.
REQ-033 rst mid-frame SHALL take precedence over pix_en and frame_start the same edge.

Structure
REQ-034 Shared package: colour constants (WALL_RGB, BEAN_RGB, BLACK), pac_dir encodings, coordinate widths.
REQ-035 One sub-module sprite_hit (one instance per sprite via generate): bounds compare plus texel offsets, combinational.

Verification
REQ-036 Sprite 1 at (100,50), pixel (110,60), rom_rgb=12'h0F0 -> rgb_out=12'h0F0 three enabled edges later, rom_addr col=10,row=10.
REQ-037 Sprites 1,2 both cover pixel -> rom_id=1; rom_rgb=KEY_RGB with is_bean=1 -> rgb_out=12'hFF0.
REQ-038 Player at (0,0), dir 01, pixel (3,5) -> rom_addr texel {3,26}; dir 11 -> {5,28}.
REQ-039 Change spr_x mid-frame -> output unchanged until next frame_start; ANIM_DIV=2, four frame_start -> anim_phase toggles twice.
REQ-040 pix_en low 5 clks mid-stream -> rgb_out frozen; over=1 -> 12'h000 regardless of wall/sprite.
REQ-041 rst asserted mid-frame -> next edge rgb_out=0, rgb_valid=0, all sprites hidden until frame_start.
